// File: rtl/jump_target_unit.sv
// jump_target_unit: decodes j/jal/jr/jalr and produces a registered redirect
// target with a one-cycle taken pulse. It also keeps a circular return-address
// stack so that the predicted target of a return can be checked against the
// resolved register value.
//
// Optional feature macro: JTU_STATS_EN adds the saturating JumpCount and
// MispredictCount outputs.
//
// Ports:
//   Clk             in   rising-edge clock
//   Reset           in   synchronous, active-low reset
//   InstrValid      in   Instruction/PCPlus4/JumpRegister valid this cycle
//   Stall           in   freezes all state; the pulses drop to 0
//   Instruction     in   32-bit instruction word in decode
//   PCPlus4         in   address of the instruction + 4
//   JumpRegister    in   resolved rs value for jr/jalr
//   JumpAddress     out  registered redirect target
//   JumpTaken       out  one-cycle pulse; JumpAddress is valid
//   IsReturn        out  pulse aligned with JumpTaken; the jump was jr $31
//   PredAddress     out  RAS top popped for the last return
//   PredValid       out  PredAddress is meaningful (RAS was non-empty at pop)
//   Mispredict      out  pulse; the popped prediction differed from JumpRegister
//   RASCount        out  RAS occupancy, 0..RAS_DEPTH
//   JumpCount       out  (JTU_STATS_EN) accepted jumps, saturating
//   MispredictCount out  (JTU_STATS_EN) mispredicts, saturating
module jump_target_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int RAS_DEPTH  = 8,
  parameter int RAS_PTR_W  = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  InstrValid,
  input  logic                  Stall,
  input  logic [31:0]           Instruction,
  input  logic [ADDR_WIDTH-1:0] PCPlus4,
  input  logic [ADDR_WIDTH-1:0] JumpRegister,
  output logic [ADDR_WIDTH-1:0] JumpAddress,
  output logic                  JumpTaken,
  output logic                  IsReturn,
  output logic [ADDR_WIDTH-1:0] PredAddress,
  output logic                  PredValid,
  output logic                  Mispredict,
  output logic [RAS_PTR_W:0]    RASCount
`ifdef JTU_STATS_EN
  ,
  output logic [15:0]           JumpCount,
  output logic [15:0]           MispredictCount
`endif
);

  localparam logic [RAS_PTR_W:0]   CNT_FULL = (RAS_PTR_W+1)'(RAS_DEPTH);
  localparam logic [RAS_PTR_W:0]   CNT_ONE  = (RAS_PTR_W+1)'(1);
  localparam logic [RAS_PTR_W-1:0] PTR_ONE  = RAS_PTR_W'(1);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic       is_j;
  logic       is_jal;
  logic       is_jr;
  logic       is_jalr;
  logic       is_jump;
  logic       accept;
  logic       push;
  logic       pop;
  logic       ras_nonempty;

  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [ADDR_WIDTH-1:0] jump_addr_q, jump_addr_d;
  logic                  taken_q, taken_d;
  logic                  is_ret_q, is_ret_d;
  logic [ADDR_WIDTH-1:0] pred_addr_q, pred_addr_d;
  logic                  pred_valid_q, pred_valid_d;
  logic                  mispred_q, mispred_d;
  logic [RAS_PTR_W-1:0]  wptr_q, wptr_d;
  logic [RAS_PTR_W:0]    count_q, count_d;

  assign opcode  = Instruction[31:26];
  assign funct   = Instruction[5:0];
  assign rs      = Instruction[25:21];

  // Only the two real register-jump functs count; other opcode-0 functs are ALU ops.
  assign is_j    = opcode == 6'b000010;
  assign is_jal  = opcode == 6'b000011;
  assign is_jr   = opcode == 6'b000000 && funct == 6'b001000;
  assign is_jalr = opcode == 6'b000000 && funct == 6'b001001;
  assign is_jump = is_j | is_jal | is_jr | is_jalr;

  assign accept  = InstrValid & ~Stall & is_jump;
  assign push    = accept & (is_jal | is_jalr);
  // jalr $31 is a call, not a return, so only jr can pop.
  assign pop     = accept & is_jr & (rs == 5'd31);

  assign target  = (is_j | is_jal)
                 ? {PCPlus4[ADDR_WIDTH-1:28], Instruction[25:0], 2'b00}
                 : JumpRegister;

  // The write pointer names the next free slot, so the top lives one below it.
  assign ras_top      = ras_q[wptr_q - PTR_ONE];
  assign ras_nonempty = count_q != '0;

  always_comb begin
    jump_addr_d  = accept ? target : jump_addr_q;
    taken_d      = accept;
    is_ret_d     = pop;
    pred_addr_d  = pred_addr_q;
    pred_valid_d = pred_valid_q;
    mispred_d    = 1'b0;
    wptr_d       = wptr_q;
    count_d      = count_q;
    if (push) begin
      wptr_d  = wptr_q + PTR_ONE;
      count_d = (count_q == CNT_FULL) ? count_q : count_q + CNT_ONE;
    end
    if (pop) begin
      pred_valid_d = ras_nonempty;
      pred_addr_d  = ras_nonempty ? ras_top : pred_addr_q;
      mispred_d    = ras_nonempty && (ras_top != JumpRegister);
      wptr_d       = ras_nonempty ? wptr_q - PTR_ONE : wptr_q;
      count_d      = ras_nonempty ? count_q - CNT_ONE : count_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      jump_addr_q  <= '0;
      taken_q      <= 1'b0;
      is_ret_q     <= 1'b0;
      pred_addr_q  <= '0;
      pred_valid_q <= 1'b0;
      mispred_q    <= 1'b0;
      wptr_q       <= '0;
      count_q      <= '0;
    end else begin
      jump_addr_q  <= jump_addr_d;
      taken_q      <= taken_d;
      is_ret_q     <= is_ret_d;
      pred_addr_q  <= pred_addr_d;
      pred_valid_q <= pred_valid_d;
      mispred_q    <= mispred_d;
      wptr_q       <= wptr_d;
      count_q      <= count_d;
    end
  end

  // Entries are not cleared; a full push simply overwrites the oldest slot.
  always_ff @(posedge Clk) begin
    if (Reset && push) ras_q[wptr_q] <= PCPlus4;
  end

  assign JumpAddress = jump_addr_q;
  assign JumpTaken   = taken_q;
  assign IsReturn    = is_ret_q;
  assign PredAddress = pred_addr_q;
  assign PredValid   = pred_valid_q;
  assign Mispredict  = mispred_q;
  assign RASCount    = count_q;

`ifdef JTU_STATS_EN
  logic [15:0] jump_cnt_q, jump_cnt_d;
  logic [15:0] mis_cnt_q, mis_cnt_d;

  always_comb begin
    jump_cnt_d = (accept && jump_cnt_q != 16'hFFFF) ? jump_cnt_q + 16'd1 : jump_cnt_q;
    mis_cnt_d  = (mispred_d && mis_cnt_q != 16'hFFFF) ? mis_cnt_q + 16'd1 : mis_cnt_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      jump_cnt_q <= '0;
      mis_cnt_q  <= '0;
    end else begin
      jump_cnt_q <= jump_cnt_d;
      mis_cnt_q  <= mis_cnt_d;
    end
  end

  assign JumpCount       = jump_cnt_q;
  assign MispredictCount = mis_cnt_q;
`endif

endmodule

// File: tb/tb_jump_target_unit.sv
// tb_jump_target_unit: directed-vector self-checking bench for jump_target_unit.
module tb_jump_target_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InstrValid;
  logic        Stall;
  logic [31:0] Instruction;
  logic [31:0] PCPlus4;
  logic [31:0] JumpRegister;
  logic [31:0] JumpAddress;
  logic        JumpTaken;
  logic        IsReturn;
  logic [31:0] PredAddress;
  logic        PredValid;
  logic        Mispredict;
  logic [3:0]  RASCount;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] J_0040  = 32'h0800_0040;
  localparam logic [31:0] JAL_100 = 32'h0C00_0100;
  localparam logic [31:0] JAL_0   = 32'h0C00_0000;
  localparam logic [31:0] JR_31   = 32'h03E0_0008;
  localparam logic [31:0] JR_5    = 32'h00A0_0008;
  localparam logic [31:0] JALR_31 = 32'h03E0_F809;
  localparam logic [31:0] ADD_OP  = 32'h0000_0020;

  jump_target_unit dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .InstrValid   (InstrValid),
    .Stall        (Stall),
    .Instruction  (Instruction),
    .PCPlus4      (PCPlus4),
    .JumpRegister (JumpRegister),
    .JumpAddress  (JumpAddress),
    .JumpTaken    (JumpTaken),
    .IsReturn     (IsReturn),
    .PredAddress  (PredAddress),
    .PredValid    (PredValid),
    .Mispredict   (Mispredict),
    .RASCount     (RASCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic v, input logic s, input logic [31:0] ins,
                       input logic [31:0] pc4, input logic [31:0] jr);
    InstrValid   = v;
    Stall        = s;
    Instruction  = ins;
    PCPlus4      = pc4;
    JumpRegister = jr;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  JumpAddress, 32'h0);
    check({tag, "_taken"}, {31'h0, JumpTaken}, 32'h0);
    check({tag, "_ret"},   {31'h0, IsReturn}, 32'h0);
    check({tag, "_pred"},  PredAddress, 32'h0);
    check({tag, "_pv"},    {31'h0, PredValid}, 32'h0);
    check({tag, "_mis"},   {31'h0, Mispredict}, 32'h0);
    check({tag, "_cnt"},   {28'h0, RASCount}, 32'h0);
  endtask

  initial begin
    Reset = 1'b0;
    InstrValid = 1'b0; Stall = 1'b0;
    Instruction = '0; PCPlus4 = '0; JumpRegister = '0;
    idle();
    idle();
    Reset = 1'b1;
    idle();
    check_all_zero("reset");

    drive(1'b1, 1'b0, J_0040, 32'h4000_0010, 32'h0);
    check("j_addr",  JumpAddress, 32'h4000_0100);
    check("j_taken", {31'h0, JumpTaken}, 32'h1);
    check("j_ret",   {31'h0, IsReturn}, 32'h0);
    idle();
    check("j_pulse_end", {31'h0, JumpTaken}, 32'h0);
    check("j_addr_hold", JumpAddress, 32'h4000_0100);

    drive(1'b1, 1'b0, JAL_100, 32'h0000_0104, 32'h0);
    check("jal_addr", JumpAddress, 32'h0000_0400);
    check("jal_cnt",  {28'h0, RASCount}, 32'h1);
    drive(1'b1, 1'b0, JR_31, 32'h0000_0204, 32'h0000_0104);
    check("ret_addr", JumpAddress, 32'h0000_0104);
    check("ret_isret", {31'h0, IsReturn}, 32'h1);
    check("ret_pv",   {31'h0, PredValid}, 32'h1);
    check("ret_pred", PredAddress, 32'h0000_0104);
    check("ret_mis",  {31'h0, Mispredict}, 32'h0);
    check("ret_cnt",  {28'h0, RASCount}, 32'h0);

    drive(1'b1, 1'b0, JAL_100, 32'h0000_0104, 32'h0);
    drive(1'b1, 1'b0, JR_31, 32'h0000_0204, 32'h0000_0200);
    check("mis_addr", JumpAddress, 32'h0000_0200);
    check("mis_pred", PredAddress, 32'h0000_0104);
    check("mis_flag", {31'h0, Mispredict}, 32'h1);
    idle();
    check("mis_pulse_end", {31'h0, Mispredict}, 32'h0);
    check("mis_pv_hold", {31'h0, PredValid}, 32'h1);

    for (int k = 1; k <= 9; k++) drive(1'b1, 1'b0, JAL_0, 32'(4 * k), 32'h0);
    check("full_cnt", {28'h0, RASCount}, 32'h8);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, JR_31, 32'h0, 32'(36 - 4 * i));
      check($sformatf("pop%0d_pred", i), PredAddress, 32'(36 - 4 * i));
      check($sformatf("pop%0d_mis", i), {31'h0, Mispredict}, 32'h0);
      check($sformatf("pop%0d_cnt", i), {28'h0, RASCount}, 32'(7 - i));
    end
    drive(1'b1, 1'b0, JR_31, 32'h0, 32'h0000_0abc);
    check("empty_pv",    {31'h0, PredValid}, 32'h0);
    check("empty_mis",   {31'h0, Mispredict}, 32'h0);
    check("empty_cnt",   {28'h0, RASCount}, 32'h0);
    check("empty_taken", {31'h0, JumpTaken}, 32'h1);
    check("empty_addr",  JumpAddress, 32'h0000_0abc);

    drive(1'b1, 1'b0, JAL_0, 32'h0000_0050, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, JR_31, 32'h0, 32'h0000_0050);
      check($sformatf("stall%0d_taken", i), {31'h0, JumpTaken}, 32'h0);
      check($sformatf("stall%0d_cnt", i), {28'h0, RASCount}, 32'h1);
    end
    drive(1'b1, 1'b0, JR_31, 32'h0, 32'h0000_0050);
    check("unstall_taken", {31'h0, JumpTaken}, 32'h1);
    check("unstall_cnt",   {28'h0, RASCount}, 32'h0);
    check("unstall_pred",  PredAddress, 32'h0000_0050);
    idle();
    check("unstall_once",  {31'h0, JumpTaken}, 32'h0);

    drive(1'b1, 1'b0, ADD_OP, 32'h0000_0060, 32'h0000_0123);
    check("add_taken", {31'h0, JumpTaken}, 32'h0);
    check("add_cnt",   {28'h0, RASCount}, 32'h0);
    check("add_addr",  JumpAddress, 32'h0000_0050);

    drive(1'b1, 1'b0, JALR_31, 32'h0000_0060, 32'h0000_0300);
    check("jalr_addr", JumpAddress, 32'h0000_0300);
    check("jalr_ret",  {31'h0, IsReturn}, 32'h0);
    check("jalr_cnt",  {28'h0, RASCount}, 32'h1);

    drive(1'b0, 1'b0, JAL_0, 32'h0000_0070, 32'h0);
    check("inval_taken", {31'h0, JumpTaken}, 32'h0);
    check("inval_cnt",   {28'h0, RASCount}, 32'h1);

    drive(1'b1, 1'b0, JR_5, 32'h0, 32'h0000_0444);
    check("jr5_addr", JumpAddress, 32'h0000_0444);
    check("jr5_ret",  {31'h0, IsReturn}, 32'h0);
    check("jr5_cnt",  {28'h0, RASCount}, 32'h1);

    drive(1'b1, 1'b0, JR_31, 32'h0, 32'h0000_0999);
    check("pre_rst_taken", {31'h0, JumpTaken}, 32'h1);
    check("pre_rst_mis",   {31'h0, Mispredict}, 32'h1);
    Reset = 1'b0;
    drive(1'b1, 1'b1, J_0040, 32'h4000_0010, 32'h0);
    check_all_zero("midrst");
    Reset = 1'b1;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jump_target_unit.md
Name: jump_target_unit

Overview:
- Parametrised successor to the single-cycle jump address mux.
- Decodes j / jal / jr / jalr from the fetched instruction and produces a registered redirect target with a one-cycle taken pulse.
- Keeps a circular return-address stack (RAS): pushed on jal/jalr, popped on jr $31, so a return's predicted target can be compared with the resolved register value.
- Sits between decode and the PC register in the fetch loop.

Parameters:
- ADDR_WIDTH, 32, PC/target width; must be >= 29.
- RAS_DEPTH, 8, number of RAS entries; must be a power of two >= 2.
- RAS_PTR_W, 3, log2(RAS_DEPTH).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- InstrValid  in  1  Instruction/PCPlus4/JumpRegister are valid this cycle.
- Stall  in  1  pipeline stall; freezes all state.
- Instruction  in  32  instruction word in decode.
- PCPlus4  in  ADDR_WIDTH  address of the instruction + 4.
- JumpRegister  in  ADDR_WIDTH  resolved rs value for jr/jalr.
- JumpAddress  out  ADDR_WIDTH  registered redirect target.
- JumpTaken  out  1  one-cycle pulse; JumpAddress is valid.
- IsReturn  out  1  pulse aligned with JumpTaken; the jump was jr $31.
- PredAddress  out  ADDR_WIDTH  RAS top popped for this return.
- PredValid  out  1  PredAddress is meaningful (RAS was non-empty at the pop).
- Mispredict  out  1  pulse; PredValid=1 and PredAddress != JumpAddress.
- RASCount  out  RAS_PTR_W+1  current occupancy, 0..RAS_DEPTH.

Behaviour:
- Decode (combinational, internal):
  - j: opcode 000010.
  - jal: opcode 000011.
  - jr: opcode 000000, funct 001000.
  - jalr: opcode 000000, funct 001001.
  - Any other opcode-0 funct is not a jump (unlike the old block, which treated all opcode 0 as jr).
  - Return = jr with rs (Instruction[25:21]) == 31.
- Accept = InstrValid & ~Stall & (any jump).
- Target:
  - j/jal: {PCPlus4[ADDR_WIDTH-1:28], Instruction[25:0], 2'b00}.
  - jr/jalr: JumpRegister.
- Latency 1: target is registered into JumpAddress on the accepting edge; JumpTaken=1 for exactly the following cycle.
- Cycles without an accept drive JumpTaken, IsReturn, Mispredict to 0. JumpAddress, PredAddress and PredValid hold their last values.
- Stall=1: no register updates at all (pulses drop to 0); RAS and count frozen.
- Push (accepted jal/jalr):
  - Write PCPlus4 at the write pointer; pointer increments mod RAS_DEPTH.
  - RASCount increments, saturating at RAS_DEPTH.
  - Full push overwrites the oldest entry (circular); count stays at RAS_DEPTH.
- Pop (accepted return):
  - If RASCount > 0: PredAddress <= top entry, PredValid <= 1; pointer decrements mod RAS_DEPTH; count decrements.
  - Mispredict <= (top != JumpRegister).
  - If RASCount == 0: PredValid <= 0, Mispredict <= 0, pointer and count unchanged.
- jalr with rs=31 pushes only; it never pops. One instruction per cycle, so push and pop never coincide.
- Reset (Reset=0 at a rising edge, wins over everything including Stall):
  - JumpAddress=0, JumpTaken=0, IsReturn=0, PredAddress=0, PredValid=0, Mispredict=0.
  - RAS pointer=0, RASCount=0.
  - RAS entry contents need not be cleared.
  - Reset mid-sequence discards any pending pulse.

Optional Feature:
- Macro JTU_STATS_EN.
- Defined: adds outputs JumpCount [15:0] and MispredictCount [15:0].
  - JumpCount increments on each accept.
  - MispredictCount increments on each Mispredict pulse.
  - Both saturate at 16'hFFFF and reset to 0.
  - Neither counts during Stall.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset low 2 cycles, then high -> all outputs 0, RASCount=0.
- j, Instruction=32'h0800_0040, PCPlus4=32'h4000_0010 -> next cycle JumpAddress=32'h4000_0100, JumpTaken=1 for 1 cycle, IsReturn=0.
- jal at PCPlus4=32'h0000_0104, then jr $31 (32'h03E0_0008) with JumpRegister=32'h0000_0104 -> RASCount 1 then 0; IsReturn=1, PredValid=1, PredAddress=32'h0000_0104, Mispredict=0. Repeat with JumpRegister=32'h0000_0200 -> Mispredict=1.
- 9 jal with PCPlus4=4,8,...,36 (RAS_DEPTH=8) -> RASCount=8; 8 pops give PredAddress 36,32,...,8 (4 overwritten); 9th pop -> PredValid=0, Mispredict=0, RASCount stays 0.
- jr $31 presented with Stall=1 for 3 cycles, then Stall=0 -> exactly one JumpTaken pulse, one pop, one edge after Stall drops.
- Opcode 0 with funct 100000 (add), and InstrValid=0 with a valid jal -> JumpTaken=0, RASCount unchanged; Reset asserted while JumpTaken=1 -> next cycle all outputs 0.
